bin_to_bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the iterative shift-add-3 (double-dabble) method, one input bit per clock. It is the next generation of the frequency counter's combinational converter. It adds generic input width and digit count, a start/done handshake, overflow detection and held outputs. It sits between the frequency gate/count logic and the 7-segment digit driver.

---
 rtl/bin_to_bcd_pkg.sv | 11 +
 rtl/bcd_digit_adj.sv | 10 +
 rtl/bin_to_bcd_seq.sv | 114 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;
  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// Purely combinational, no handshake.
module bcd_digit_adj
  import bin_to_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);
  assign dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock; leading-zero blanking under BIN_TO_BCD_BLANK_EN.
// Latency: done in the cycle BIN_W edges after the accepting edge; start is ignored (not queued) while busy.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin_in,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                      overflow,
  output logic [DIGITS-1:0]         blank
);
  localparam int               BCD_W    = DIGIT_W * DIGITS;
  localparam int               CNT_W    = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   bcd_w, bcd_adj, bcd_shf;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_w, ovf_shf;
  logic               accept, last_shift;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_w[k*DIGIT_W +: DIGIT_W]),
      .dout (bcd_adj[k*DIGIT_W +: DIGIT_W])
    );
  end

  // The bit pushed out of the top digit is the part of the value >= 10^DIGITS.
  assign bcd_shf    = {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
  assign ovf_shf    = ovf_w | bcd_adj[BCD_W-1];
  assign accept     = start & ((state == IDLE) | (state == DONE));
  assign last_shift = (state == SHIFT) && (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE) || (state == DONE);
    busy  = (state == SHIFT);
    done  = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_sr   <= '0;
      bcd_w    <= '0;
      ovf_w    <= 1'b0;
      cnt      <= '0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        bin_sr <= bin_in;
        bcd_w  <= '0;
        ovf_w  <= 1'b0;
        cnt    <= CNT_LOAD;
      end else if (state == SHIFT) begin
        bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
        bcd_w  <= bcd_shf;
        ovf_w  <= ovf_shf;
        cnt    <= cnt - CNT_W'(1);
      end
      if (last_shift) begin
        bcd_out  <= bcd_shf;
        overflow <= ovf_shf;
      end
    end
  end

`ifdef BIN_TO_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;
  logic              hi_zero;

  // Units digit is never blanked so zero still shows a single "0".
  always_comb begin
    blank_nxt = '0;
    hi_zero   = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      hi_zero      = hi_zero & (bcd_shf[k*DIGIT_W +: DIGIT_W] == 4'd0);
      blank_nxt[k] = hi_zero;
    end
    if (ovf_shf) blank_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset)           blank <= '0;
    else if (last_shift) blank <= blank_nxt;
  end
`else
  assign blank = '0;
`endif
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench: a 32-bit/10-digit converter and a 16-bit/4-digit converter.
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] bin_a = '0;
  logic [15:0] bin_b = '0;
  logic        ready_a, busy_a, done_a, ovf_a;
  logic        ready_b, busy_b, done_b, ovf_b;
  logic [39:0] bcd_a;
  logic [15:0] bcd_b;
  logic [9:0]  blank_a;
  logic [3:0]  blank_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(32), .DIGITS(10)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bin_in(bin_a),
    .ready(ready_a), .busy(busy_a), .done(done_a),
    .bcd_out(bcd_a), .overflow(ovf_a), .blank(blank_a)
  );

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bin_in(bin_b),
    .ready(ready_b), .busy(busy_b), .done(done_b),
    .bcd_out(bcd_b), .overflow(ovf_b), .blank(blank_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] blank_exp(input logic [39:0] b, input int nd, input bit ovf);
    logic [9:0] r;
    r = '0;
`ifdef BIN_TO_BCD_BLANK_EN
    begin
      bit z;
      z = 1'b1;
      for (int k = nd - 1; k >= 1; k--) begin
        z    = z & (b[4*k +: 4] == 4'd0);
        r[k] = z;
      end
      if (ovf) r = '0;
    end
`endif
    return r;
  endfunction

  task automatic launch(input bit sel, input logic [31:0] v);
    @(negedge clk);
    if (sel) begin bin_b = v[15:0]; start_b = 1'b1; end
    else     begin bin_a = v;       start_a = 1'b1; end
  endtask

  // Counts edges from the accepting edge (cycle 1) until done is seen.
  task automatic run_wait(input bit sel, input int p1, input int p2,
                          output int lat, output logic [39:0] mid);
    lat = -1;
    mid = '0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin start_a = 1'b0; start_b = 1'b0; end
      if (cyc == p1 || cyc == p2) begin start_a = 1'b1; bin_a = 32'd999999; end
      if (cyc == p1 + 1 || cyc == p2 + 1) start_a = 1'b0;
      if (cyc == 2) begin
        chk("busy_during", sel ? busy_b : busy_a, 1);
        chk("ready_during", sel ? ready_b : ready_a, 0);
      end
      if (cyc == 8) mid = sel ? {24'd0, bcd_b} : bcd_a;
      if (sel ? done_b : done_a) begin
        lat = cyc;
        break;
      end
    end
  endtask

  task automatic check_a(input string tag, input logic [39:0] exp);
    chk({tag, "_bcd"}, bcd_a, exp);
    chk({tag, "_ovf"}, ovf_a, 0);
    chk({tag, "_blank"}, blank_a, blank_exp(exp, 10, 1'b0));
  endtask

  task automatic conv_a(input string tag, input logic [31:0] v, input logic [39:0] exp);
    int lat;
    logic [39:0] mid;
    launch(1'b0, v);
    run_wait(1'b0, 0, 0, lat, mid);
    chk({tag, "_lat"}, lat, 33);
    check_a(tag, exp);
  endtask

  localparam int NPROG = 10;
  logic [31:0] prog_v [NPROG] = '{32'd1, 32'd3, 32'd7, 32'd15, 32'd31, 32'd63,
                                  32'd191, 32'd1215, 32'd34015, 32'd1082303};
  logic [39:0] prog_e [NPROG] = '{40'h1, 40'h3, 40'h7, 40'h15, 40'h31, 40'h63,
                                  40'h191, 40'h1215, 40'h34015, 40'h1082303};

  initial begin
    int          lat, ndone;
    logic [39:0] mid;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_bcd", bcd_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_blank", blank_a, 0);
    reset = 1'b0;

    // Zero: single "0" digit shown
    conv_a("zero", 32'd0, 40'h0);
    chk("zero_blank_const", blank_a, blank_exp(40'h0, 10, 1'b0));
    @(posedge clk); #1;
    chk("zero_done_pulse", done_a, 0);
    chk("zero_hold", bcd_a, 0);

    // Large value, then back-to-back with start held during DONE
    conv_a("big1", 32'd1234567890, 40'h1234567890);
    bin_a   = 32'd4294967295;
    start_a = 1'b1;
    run_wait(1'b0, 0, 0, lat, mid);
    chk("b2b_lat", lat, 33);
    chk("b2b_hold_mid", mid, 40'h1234567890);
    check_a("b2b", 40'h4294967295);

    // Four-digit instance: overflow truncation and full-scale
    launch(1'b1, 32'd12345);
    run_wait(1'b1, 0, 0, lat, mid);
    chk("d4_ovf_lat", lat, 17);
    chk("d4_ovf_bcd", bcd_b, 16'h2345);
    chk("d4_ovf_flag", ovf_b, 1);
    chk("d4_ovf_blank", blank_b, 0);
    launch(1'b1, 32'd9999);
    run_wait(1'b1, 0, 0, lat, mid);
    chk("d4_9999_bcd", bcd_b, 16'h9999);
    chk("d4_9999_ovf", ovf_b, 0);
    chk("d4_9999_blank", blank_b, 0);
    launch(1'b1, 32'd7);
    run_wait(1'b1, 0, 0, lat, mid);
    chk("d4_7_bcd", bcd_b, 16'h0007);
    chk("d4_7_ovf", ovf_b, 0);
    chk("d4_7_blank", blank_b, blank_exp(40'h7, 4, 1'b0));

    // Progressively set bits
    for (int i = 0; i < NPROG; i++) conv_a($sformatf("prog%0d", i), prog_v[i], prog_e[i]);

    // start pulses mid-conversion are ignored
    launch(1'b0, 32'd555);
    run_wait(1'b0, 5, 10, lat, mid);
    chk("ign_lat", lat, 33);
    check_a("ign", 40'h555);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done_a) ndone++;
    end
    chk("ign_extra_done", ndone, 0);

    // Reset during conversion aborts it
    launch(1'b0, 32'd987654321);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) start_a = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_ready", ready_a, 1);
    chk("abort_busy", busy_a, 0);
    chk("abort_bcd", bcd_a, 0);
    chk("abort_ovf", ovf_a, 0);
    chk("abort_blank", blank_a, 0);
    chk("abort_bcd_b", bcd_b, 0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done_a) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    conv_a("after_abort", 32'd42, 40'h42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
